axi_burst_ram_slave: RTL and testbench

- AXI-style burst responder that owns a word-addressed RAM. It is the other end of the data-cache / arbiter master interface: it accepts the AR/R and AW/W/B channels the cache drives, using the same signal set with no IDs and no resp fields.
- Serves 8-beat cache-line refills and evictions, plus single-beat uncached accesses.
- Used as the on-chip scratch memory and as the system-level memory model for the MIPS pipeline.

---
 rtl/axi_burst_ram_slave.sv | 183 ++++++++++++++++++
 tb/tb_axi_burst_ram_slave.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_ram_slave.sv
// AXI-style burst RAM responder: INCR read/write bursts into a word-addressed RAM.
// Independent read and write FSMs share one byte-writable memory array.
module axi_burst_ram_slave #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned RD_DELAY   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic        bvalid,
    input  logic        bready,
    output logic        proto_err
);

    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0]  DLY_LAST = 4'((RD_DELAY == 32'd0) ? 32'd0 : RD_DELAY - 32'd1);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    logic [31:0] mem_q [DEPTH];

    r_state_e               r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0]  r_idx_q, r_idx_d;
    logic [3:0]             r_len_q, r_len_d;
    logic [3:0]             r_cnt_q, r_cnt_d;
    logic [3:0]             r_dly_q, r_dly_d;

    w_state_e               w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0]  w_idx_q, w_idx_d;
    logic [3:0]             w_len_q, w_len_d;
    logic [3:0]             w_cnt_q, w_cnt_d;
    logic                   proto_err_q, proto_err_d;
    logic                   mem_we_c;
    logic                   w_final_c;

    // Address bits outside the word index and awsize carry no function here.
    logic unused_c;
    assign unused_c = ^{araddr[31:ADDR_WIDTH+2], araddr[1:0],
                        awaddr[31:ADDR_WIDTH+2], awaddr[1:0], awsize};

    assign arready   = (r_state_q == R_IDLE);
    assign rvalid    = (r_state_q == R_DATA);
    assign rlast     = rvalid && (r_cnt_q == r_len_q);
    assign rdata     = rvalid ? mem_q[r_idx_q] : 32'd0;

    assign awready   = (w_state_q == W_IDLE);
    assign wready    = (w_state_q == W_DATA);
    assign bvalid    = (w_state_q == W_RESP);
    assign proto_err = proto_err_q;
    assign w_final_c = (w_cnt_q == w_len_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q   <= R_IDLE;
            r_idx_q     <= '0;
            r_len_q     <= '0;
            r_cnt_q     <= '0;
            r_dly_q     <= '0;
            w_state_q   <= W_IDLE;
            w_idx_q     <= '0;
            w_len_q     <= '0;
            w_cnt_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            r_state_q   <= r_state_d;
            r_idx_q     <= r_idx_d;
            r_len_q     <= r_len_d;
            r_cnt_q     <= r_cnt_d;
            r_dly_q     <= r_dly_d;
            w_state_q   <= w_state_d;
            w_idx_q     <= w_idx_d;
            w_len_q     <= w_len_d;
            w_cnt_q     <= w_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Read burst sequencing; the index wraps naturally at the RAM depth.
    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_dly_d   = r_dly_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    r_idx_d   = araddr[ADDR_WIDTH+1:2];
                    r_len_d   = arlen;
                    r_cnt_d   = 4'd0;
                    r_dly_d   = 4'd0;
                    r_state_d = (RD_DELAY == 32'd0) ? R_DATA : R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_dly_q == DLY_LAST) begin
                    r_state_d = R_DATA;
                end else begin
                    r_dly_d = r_dly_q + 4'd1;
                end
            end
            R_DATA: begin
                if (rready) begin
                    r_idx_d = r_idx_q + ADDR_WIDTH'(1);
                    r_cnt_d = r_cnt_q + 4'd1;
                    if (rlast) begin
                        r_state_d = R_IDLE;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Write burst sequencing; the beat count, not wlast, ends the burst.
    always_comb begin
        w_state_d   = w_state_q;
        w_idx_d     = w_idx_q;
        w_len_d     = w_len_q;
        w_cnt_d     = w_cnt_q;
        proto_err_d = proto_err_q;
        mem_we_c    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid) begin
                    w_idx_d   = awaddr[ADDR_WIDTH+1:2];
                    w_len_d   = awlen;
                    w_cnt_d   = 4'd0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    mem_we_c = 1'b1;
                    w_idx_d  = w_idx_q + ADDR_WIDTH'(1);
                    w_cnt_d  = w_cnt_q + 4'd1;
                    if (wlast != w_final_c) begin
                        proto_err_d = 1'b1;
                    end
                    if (w_final_c) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // RAM array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int k = 0; k < 4; k++) begin
                if (wstrb[k]) begin
                    mem_q[w_idx_q][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_ram_slave.sv
// Directed bench for axi_burst_ram_slave: single-beat vector table plus burst,
// backpressure, delay, wrap/concurrency, protocol-error and reset sequences.
module tb_axi_burst_ram_slave;

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;
    logic        proto_err;

    // Second instance with a read delay; shares every input except arvalid.
    logic        d_arvalid;
    logic        d_arready;
    logic [31:0] d_rdata;
    logic        d_rlast;
    logic        d_rvalid;
    logic        d_awready;
    logic        d_wready;
    logic        d_bvalid;
    logic        d_proto_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] wbuf [16];
    logic [31:0] rbuf [16];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [5];

    axi_burst_ram_slave #(.ADDR_WIDTH(12), .RD_DELAY(0)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready), .proto_err(proto_err)
    );

    axi_burst_ram_slave #(.ADDR_WIDTH(12), .RD_DELAY(3)) u_dly (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arlen(arlen), .arvalid(d_arvalid), .arready(d_arready),
        .rdata(d_rdata), .rlast(d_rlast), .rvalid(d_rvalid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(d_awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(d_wready),
        .bvalid(d_bvalid), .bready(bready), .proto_err(d_proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Write burst from wbuf; last_at >= 0 moves wlast to that beat instead of the final one.
    task automatic do_write(input logic [31:0] addr, input int len, input logic [3:0] strb,
                            input int last_at);
        @(negedge clk);
        chk1("awready_idle", awready, 1'b1);
        chk1("wready_idle", wready, 1'b0);
        awaddr  = addr;
        awlen   = 4'(len);
        awvalid = 1'b1;
        @(posedge clk);
        for (int b = 0; b <= len; b++) begin
            @(negedge clk);
            awvalid = 1'b0;
            chk1("wready_beat", wready, 1'b1);
            wvalid = 1'b1;
            wdata  = wbuf[b];
            wstrb  = strb;
            wlast  = (last_at < 0) ? (b == len) : (b == last_at);
            @(posedge clk);
        end
        @(negedge clk);
        wvalid = 1'b0;
        wlast  = 1'b0;
        chk1("bvalid_set", bvalid, 1'b1);
        chk1("wready_resp", wready, 1'b0);
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
        chk1("bvalid_clr", bvalid, 1'b0);
    endtask

    // Read burst compared against rbuf; stall drives rready as 1,0,0,1,0,0...
    task automatic do_read(input logic [31:0] addr, input int len, input bit stall);
        int b = 0;
        int c = 0;
        @(negedge clk);
        chk1("arready_idle", arready, 1'b1);
        araddr  = addr;
        arlen   = 4'(len);
        arvalid = 1'b1;
        @(posedge clk);
        while (b <= len) begin
            @(negedge clk);
            arvalid = 1'b0;
            rready  = stall ? (c % 3 == 0) : 1'b1;
            chk1("rvalid_beat", rvalid, 1'b1);
            chk32("rdata_beat", rdata, rbuf[b]);
            chk1("rlast_beat", rlast, b == len);
            chk1("arready_busy", arready, 1'b0);
            @(posedge clk);
            if (rready) b++;
            c++;
        end
        @(negedge clk);
        rready = 1'b0;
        chk1("rvalid_end", rvalid, 1'b0);
        chk32("rdata_idle", rdata, 32'd0);
        chk1("arready_end", arready, 1'b1);
    endtask

    initial begin
        vt[0] = '{addr: 32'h0000_0204, wdata: 32'hDEAD_BEEF, strb: 4'hF, exp: 32'hDEAD_BEEF};
        vt[1] = '{addr: 32'h0000_0204, wdata: 32'h0055_0000, strb: 4'h4, exp: 32'hDE55_BEEF};
        vt[2] = '{addr: 32'h0000_0206, wdata: 32'h0000_00AA, strb: 4'h1, exp: 32'hDE55_BEAA};
        vt[3] = '{addr: 32'h0000_0204, wdata: 32'h1122_3344, strb: 4'hA, exp: 32'h1155_33AA};
        vt[4] = '{addr: 32'h0000_3FFC, wdata: 32'h0BAD_F00D, strb: 4'hF, exp: 32'h0BAD_F00D};

        rst = 1'b1;
        araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0; d_arvalid = 1'b0;
        awaddr = '0; awlen = '0; awsize = 3'd2; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_arready", arready, 1'b1);
        chk1("rst_awready", awready, 1'b1);
        chk1("rst_rvalid", rvalid, 1'b0);
        chk1("rst_rlast", rlast, 1'b0);
        chk32("rst_rdata", rdata, 32'd0);
        chk1("rst_wready", wready, 1'b0);
        chk1("rst_bvalid", bvalid, 1'b0);
        chk1("rst_proto_err", proto_err, 1'b0);
        chk1("rst_d_rvalid", d_rvalid, 1'b0);
        rst = 1'b0;

        // Single-beat uncached accesses with byte strobes.
        for (int i = 0; i < 5; i++) begin
            wbuf[0] = vt[i].wdata;
            do_write(vt[i].addr, 0, vt[i].strb, -1);
            rbuf[0] = vt[i].exp;
            do_read(vt[i].addr, 0, 1'b0);
        end

        // Line refill, then the same line under backpressure.
        for (int i = 0; i < 8; i++) begin
            wbuf[i] = 32'hA0 + 32'(i);
            rbuf[i] = 32'hA0 + 32'(i);
        end
        do_write(32'h40, 7, 4'hF, -1);
        do_read(32'h40, 7, 1'b0);
        do_read(32'h40, 7, 1'b1);

        // Delayed instance: first rvalid four cycles after the AR handshake.
        @(negedge clk);
        chk1("dly_arready", d_arready, 1'b1);
        araddr = 32'h40; arlen = 4'd0; d_arvalid = 1'b1; rready = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            d_arvalid = 1'b0;
            chk1("dly_wait_rvalid", d_rvalid, 1'b0);
        end
        @(negedge clk);
        chk1("dly_rvalid", d_rvalid, 1'b1);
        chk32("dly_rdata", d_rdata, 32'hA0);
        chk1("dly_rlast", d_rlast, 1'b1);
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rready = 1'b0;
        chk1("dly_rvalid_end", d_rvalid, 1'b0);

        // Dirty eviction and read-back.
        for (int i = 0; i < 8; i++) begin
            wbuf[i] = 32'h11 * 32'(i + 1);
            rbuf[i] = 32'h11 * 32'(i + 1);
        end
        do_write(32'h1000, 7, 4'hF, -1);
        do_read(32'h1000, 7, 1'b0);

        // Wrap across the top of the RAM with a concurrent write to index 0.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h1400 + 32'(i);
        do_write(32'h3FF8, 3, 4'hF, -1);
        @(negedge clk);
        awaddr = 32'h0; awlen = 4'd0; awvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        chk1("cc_wready", wready, 1'b1);
        araddr = 32'h3FF8; arlen = 4'd3; arvalid = 1'b1; rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        chk32("cc_beat0", rdata, 32'h1400);
        @(negedge clk);
        chk32("cc_beat1", rdata, 32'h1401);
        @(negedge clk);
        chk32("cc_beat2_old", rdata, 32'h1402);
        wvalid = 1'b1; wdata = 32'h5A5A_5A5A; wstrb = 4'hF; wlast = 1'b1;
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
        chk32("cc_beat3", rdata, 32'h1403);
        chk1("cc_rlast", rlast, 1'b1);
        chk1("cc_bvalid", bvalid, 1'b1);
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        chk1("cc_rvalid_end", rvalid, 1'b0);
        chk1("cc_bvalid_end", bvalid, 1'b0);
        rbuf[0] = 32'h5A5A_5A5A;
        do_read(32'h0, 0, 1'b0);

        // Early wlast flags proto_err but the burst still runs eight beats.
        chk1("perr_before", proto_err, 1'b0);
        for (int i = 0; i < 8; i++) begin
            wbuf[i] = 32'h800 + 32'(i);
            rbuf[i] = 32'h800 + 32'(i);
        end
        do_write(32'h800, 7, 4'hF, 2);
        chk1("perr_set", proto_err, 1'b1);
        do_read(32'h800, 7, 1'b0);
        chk1("perr_sticky", proto_err, 1'b1);

        // Async reset in the middle of a read burst.
        @(negedge clk);
        araddr = 32'h1000; arlen = 4'd7; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        chk1("mid_rvalid", rvalid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("arst_rvalid", rvalid, 1'b0);
        chk1("arst_arready", arready, 1'b1);
        chk1("arst_proto_err", proto_err, 1'b0);
        chk32("arst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) rbuf[i] = 32'h11 * 32'(i + 1);
        do_read(32'h1000, 7, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
